// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RISC-V M-extension divide/remainder unit
// (DIV, DIVU, REM, REMU). Special cases (divide by zero, signed overflow)
// resolve straight to DONE. All other requests take SETUP, WIDTH restoring
// shift-subtract iterations, and FIXUP before the result is presented.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   flush        kill the in-flight operation; no response is produced
//   req_*        request handshake: op (funct3), rs1 dividend, rs2 divisor, tag
//   resp_*       response handshake: data (quotient or remainder), tag
//   busy         high whenever the sequencer is not idle
module div_sequencer #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_rs1,
   input  logic [WIDTH-1:0] req_rs2,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic [TAG_W-1:0] resp_tag,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ITER, S_FIXUP, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;   // raw rs1 until SETUP, then shifting dividend
   logic [WIDTH-1:0] dvs_q, dvs_d;   // raw rs2 until SETUP, then divisor magnitude
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;

   logic             sgn;
   logic [WIDTH:0]   trial, diff;

   // bit 2 of funct3 carries no meaning here
   logic unused_op;
   assign unused_op = req_op[2];

   assign req_ready  = (state_q == S_IDLE) && !flush && !rst;
   assign resp_valid = (state_q == S_DONE);
   assign resp_data  = data_q;
   assign resp_tag   = tag_q;
   assign busy       = (state_q != S_IDLE);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      tag_d   = tag_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      sgn     = !op_q[0];
      // One extra bit: the shifted partial remainder can exceed WIDTH bits
      // when the divisor has its MSB set.
      trial   = {rem_q, dvd_q[WIDTH-1]};
      diff    = trial - {1'b0, dvs_q};

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               op_d  = req_op[1:0];
               tag_d = req_tag;
               dvd_d = req_rs1;
               dvs_d = req_rs2;
               if (req_rs2 == '0) begin
                  data_d  = req_op[1] ? req_rs1 : '1;
                  state_d = S_DONE;
               end else if (!req_op[0] && req_rs1 == MIN_NEG && req_rs2 == '1) begin
                  data_d  = req_op[1] ? '0 : MIN_NEG;
                  state_d = S_DONE;
               end else begin
                  state_d = S_SETUP;
               end
            end
         end
         S_SETUP: begin
            dvd_d   = (sgn && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
            dvs_d   = (sgn && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
            negq_d  = sgn && (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
            negr_d  = sgn && dvd_q[WIDTH-1];
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = '0;
            state_d = S_ITER;
         end
         S_ITER: begin
            dvd_d = dvd_q << 1;
            if (!diff[WIDTH]) begin   // no borrow: trial >= divisor
               rem_d = diff[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = trial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) state_d = S_FIXUP;
         end
         S_FIXUP: begin
            if (op_q[1]) data_d = negr_q ? -rem_q : rem_q;
            else         data_d = negq_q ? -quo_q : quo_q;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // flush wins over everything, including a response handshake
      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         tag_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         tag_q   <= tag_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: hand-computed quotients/remainders,
// latency in cycles after acceptance, back-pressure and flush behaviour.
module tb_div_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic [4:0]  req_tag;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic [4:0]  resp_tag;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

   always #5 clk = ~clk;

   div_sequencer #(.WIDTH(32), .TAG_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_rs1    (req_rs1),
      .req_rs2    (req_rs2),
      .req_tag    (req_tag),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_tag   (resp_tag),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one request, measure latency (cycle 0 = accept cycle), check result,
   // optionally stall the response for 'hold' cycles, then complete it.
   task automatic do_req(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] exp, input int exp_lat, input int hold);
      int lat;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
      @(posedge clk); #1;
      // later changes on req_* must not matter
      req_valid = 1'b0; req_op = 3'($urandom); req_rs1 = $urandom; req_rs2 = $urandom;
      req_tag = 5'($urandom);
      lat = 1;
      while (!resp_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, ".lat"}, 32'(lat), 32'(exp_lat));
      chk({nm, ".data"}, resp_data, exp);
      chk({nm, ".tag"}, 32'(resp_tag), 32'(tag));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({nm, ".hold_valid"}, 32'(resp_valid), 32'd1);
         chk({nm, ".hold_data"}, resp_data, exp);
         chk({nm, ".hold_tag"}, 32'(resp_tag), 32'(tag));
         chk({nm, ".hold_rdy"}, 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk({nm, ".post_valid"}, 32'(resp_valid), 32'd0);
      chk({nm, ".post_rdy"}, 32'(req_ready), 32'd1);
      chk({nm, ".post_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int seen;
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = '0; req_rs1 = '0;
      req_rs2 = '0; req_tag = '0; resp_ready = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst.req_ready", 32'(req_ready), 32'd0);
      chk("rst.resp_valid", 32'(resp_valid), 32'd0);
      chk("rst.resp_data", resp_data, 32'd0);
      chk("rst.resp_tag", 32'(resp_tag), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst.req_ready_after", 32'(req_ready), 32'd1);

      do_req("divu_100_7",  OP_DIVU, 32'd100,        32'd7,          5'd1,  32'd14,         35, 0);
      do_req("remu_100_7",  OP_REMU, 32'd100,        32'd7,          5'd2,  32'd2,          35, 0);
      do_req("div_m7_2",    OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  35, 0);
      do_req("rem_m7_2",    OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF,  35, 0);
      do_req("rem_7_m2",    OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd5,  32'd1,          35, 0);
      do_req("div_m100_7",  OP_DIV,  32'hFFFF_FF9C,  32'd7,          5'd6,  32'hFFFF_FFF2,  35, 0);
      do_req("div_5_0",     OP_DIV,  32'd5,          32'd0,          5'd7,  32'hFFFF_FFFF,  1,  0);
      do_req("remu_5_0",    OP_REMU, 32'd5,          32'd0,          5'd8,  32'd5,          1,  0);
      do_req("div_ovf",     OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000,  1,  0);
      do_req("rem_ovf",     OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'd0,          1,  0);
      // unsigned view of the same operands: 2^31 / (2^32-1) = 0
      do_req("divu_ovf",    OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0,          35, 0);
      // divisor MSB set: partial remainder needs the extra trial bit
      do_req("remu_big",    OP_REMU, 32'hFFFF_FFFF,  32'h8000_0001,  5'd12, 32'h7FFF_FFFE,  35, 0);
      do_req("divu_max_1",  OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd13, 32'hFFFF_FFFF,  35, 0);
      do_req("hold_divu",   OP_DIVU, 32'd100,        32'd7,          5'd14, 32'd14,         35, 3);

      // flush during ITER with a competing request in the same cycle
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_DIVU; req_rs1 = 32'd100; req_rs2 = 32'd7; req_tag = 5'd21;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      chk("flush.busy_before", 32'(busy), 32'd1);
      flush = 1'b1; req_valid = 1'b1; req_op = OP_DIVU; req_rs1 = 32'd50;
      req_rs2 = 32'd5; req_tag = 5'd22;
      #1;
      chk("flush.req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; req_valid = 1'b0;
      chk("flush.busy_after", 32'(busy), 32'd0);
      chk("flush.resp_valid", 32'(resp_valid), 32'd0);
      seen = 0;
      for (int i = 0; i < 45; i++) begin
         @(posedge clk); #1;
         if (resp_valid || busy) seen++;
      end
      chk("flush.no_resp", 32'(seen), 32'd0);

      do_req("divu_9_3",    OP_DIVU, 32'd9,          32'd3,          5'd23, 32'd3,          35, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
